// File: rtl/seg7_pkg.sv
// Active-low 7-segment patterns ({A,B,C,D,E,F,G}) and BCD helpers.
// Shared by the decoder and the counter top level.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic bcd_valid(input logic [3:0] v);
    return (v <= 4'd9);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; zero latency, no flow control.
// Non-BCD codes light nothing.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit up/down BCD counter with tick prescaler, wrap pulse and registered 7-segment outputs.
// COUNT/WRAP update on the sampling edge, SEG lags COUNT by one cycle; no backpressure (EN freezes).
module bcd_counter_display
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 25_000_000,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  DIR,
  input  logic                  CLR,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic [7*DIGITS-1:0]   SEG,
  output logic                  WRAP
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] count_q, count_d, step_val, load_val;
  logic [7*DIGITS-1:0] seg_q, seg_d, dec;
  logic [DIGITS-1:0]   blank;
  logic                wrap_q, wrap_d;
  logic                tick, carry, zero_above;

  assign tick = EN && (presc_q == PRESC_LAST);

  // Ripple carry (up) or borrow (down) through the digits; a carry out of the top digit is a wrap.
  always_comb begin
    carry    = 1'b1;
    step_val = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (DIR) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    load_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_val[4*i +: 4] = bcd_valid(LOAD_VAL[4*i +: 4]) ? LOAD_VAL[4*i +: 4] : 4'd0;
    end
  end

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (CLR) begin
      presc_d = '0;
      count_d = '0;
    end else if (LOAD) begin
      presc_d = '0;
      count_d = load_val;
    end else if (EN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        count_d = step_val;
        wrap_d  = carry;
      end
    end
  end

  // A digit above 0 is blanked only while it and every higher digit read zero.
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (count_q[4*i +: 4] == 4'd0);
      blank[i]   = LZ_BLANK && zero_above;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decoder u_dec (
      .bcd_i (count_q[4*g +: 4]),
      .seg_o (dec[7*g +: 7])
    );
  end

  always_comb begin
    seg_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_d[7*i +: 7] = blank[i] ? SEG_BLANK : dec[7*i +: 7];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        seg_q[7*i +: 7] <= (LZ_BLANK && i > 0) ? SEG_BLANK : SEG_0;
      end
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
    end
  end

  assign COUNT = count_q;
  assign SEG   = seg_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Scoreboard bench: a 2-digit plain and a 3-digit blanking counter share control inputs;
// an integer reference model queues expected outputs each cycle and a monitor pops and compares.
module tb_bcd_counter_display;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n, en, dir, clr, load;
  logic [7:0]  ld_a;
  logic [11:0] ld_b;
  logic [7:0]  cnt_a;
  logic [11:0] cnt_b;
  logic [13:0] seg_a;
  logic [20:0] seg_b;
  logic        wrap_a, wrap_b;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [11:0] cnt;
    logic        wrap;
    logic [20:0] seg;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int   nd   [2] = '{2, 3};
  int   maxv [2] = '{99, 999};
  bit   lzb  [2] = '{1'b0, 1'b1};
  int   mval [2] = '{0, 0};
  int   mpres[2] = '{0, 0};
  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  always #5 clk = ~clk;

  bcd_counter_display #(.DIGITS(2), .TICK_DIV(TD), .LZ_BLANK(1'b0)) dut_a (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIR(dir), .CLR(clr), .LOAD(load),
    .LOAD_VAL(ld_a), .COUNT(cnt_a), .SEG(seg_a), .WRAP(wrap_a)
  );

  bcd_counter_display #(.DIGITS(3), .TICK_DIV(TD), .LZ_BLANK(1'b1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIR(dir), .CLR(clr), .LOAD(load),
    .LOAD_VAL(ld_b), .COUNT(cnt_b), .SEG(seg_b), .WRAP(wrap_b)
  );

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] to_bcd(input int v, input int n);
    logic [11:0] r = '0;
    for (int i = 0; i < n; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [20:0] to_seg(input int v, input int n, input bit lz);
    logic [20:0] r = '0;
    for (int i = 0; i < n; i++) begin
      if (lz && i > 0 && (v / pow10(i)) == 0) r[7*i +: 7] = 7'b1111111;
      else r[7*i +: 7] = seg_tab[(v / pow10(i)) % 10];
    end
    return r;
  endfunction

  function automatic int from_load(input logic [11:0] lv, input int n);
    int s = 0;
    int d;
    for (int i = 0; i < n; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      s = s + d * pow10(i);
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: count held as an integer, stepped with modular arithmetic.
  always @(posedge clk) begin : model
    exp_t        e;
    logic [11:0] lv;
    bit          tk;
    for (int k = 0; k < 2; k++) begin
      lv     = (k == 0) ? {4'h0, ld_a} : ld_b;
      e.wrap = 1'b0;
      if (!rst_n) begin
        mval[k]  = 0;
        mpres[k] = 0;
        e.seg    = to_seg(0, nd[k], lzb[k]);
      end else begin
        e.seg = to_seg(mval[k], nd[k], lzb[k]);
        tk    = en && (mpres[k] == TD - 1);
        if (clr) begin
          mval[k]  = 0;
          mpres[k] = 0;
        end else if (load) begin
          mval[k]  = from_load(lv, nd[k]);
          mpres[k] = 0;
        end else if (en) begin
          mpres[k] = tk ? 0 : mpres[k] + 1;
          if (tk) begin
            if (dir) begin
              e.wrap  = (mval[k] == maxv[k]);
              mval[k] = (mval[k] + 1) % (maxv[k] + 1);
            end else begin
              e.wrap  = (mval[k] == 0);
              mval[k] = (mval[k] + maxv[k]) % (maxv[k] + 1);
            end
          end
        end
      end
      e.cnt = to_bcd(mval[k], nd[k]);
      if (k == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  end

  always @(posedge clk) begin : monitor
    exp_t ea, eb;
    #1;
    if (qa.size() == 0 || qb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got %0d/%0d entries expected >=1", qa.size(), qb.size());
    end else begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("cnt_a",  32'(cnt_a),  32'(ea.cnt[7:0]));
      chk("wrap_a", 32'(wrap_a), 32'(ea.wrap));
      chk("seg_a",  32'(seg_a),  32'(ea.seg[13:0]));
      chk("cnt_b",  32'(cnt_b),  32'(eb.cnt));
      chk("wrap_b", 32'(wrap_b), 32'(eb.wrap));
      chk("seg_b",  32'(seg_b),  32'(eb.seg));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b1; clr = 1'b0; load = 1'b0;
    ld_a = '0; ld_b = '0;
    cyc(3);
    rst_n = 1'b1; en = 1'b1;
    cyc(30);
    ld_a = 8'h98; ld_b = 12'h998; load = 1'b1; cyc(1); load = 1'b0;
    cyc(14);
    clr = 1'b1; cyc(1); clr = 1'b0; dir = 1'b0;
    cyc(14);
    clr = 1'b1; load = 1'b1; ld_a = 8'h55; ld_b = 12'h555; cyc(1);
    clr = 1'b0; load = 1'b0;
    cyc(3);
    ld_a = 8'hA3; ld_b = 12'hF03; load = 1'b1; cyc(1); load = 1'b0;
    cyc(2);
    en = 1'b0; cyc(10);
    en = 1'b1; dir = 1'b1; cyc(10);
    ld_a = 8'h05; ld_b = 12'h005; load = 1'b1; cyc(1); load = 1'b0;
    cyc(6);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt_a", 32'(cnt_a), 32'h0);
    chk("async_rst_cnt_b", 32'(cnt_b), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    repeat (500) begin
      en    = ($urandom_range(0, 7) != 0);
      dir   = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 40) == 0);
      load  = ($urandom_range(0, 25) == 0);
      ld_a  = 8'($urandom);
      ld_b  = 12'($urandom);
      rst_n = ($urandom_range(0, 200) != 0);
      cyc(1);
    end
    rst_n = 1'b1; clr = 1'b0; load = 1'b0;
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
